wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order memory1 writeback stream and the multi-cycle mul/div unit. It also keeps a 32-entry pending-destination scoreboard for issued mul/div ops and raises a decode stall on RAW/WAW hits, which covers results that the forwarding network cannot supply. It sits between memory1/muldiv and the register file, beside the forwarding unit, and its stall is ORed with the forwarding stall at decode.

## Interface
Parameters:
- XLEN, 32, data width
- STARVE_LIMIT, 4, consecutive denied cycles before the buffered mul/div result is forced onto the port (1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem1_wb_valid  in  1  memory1 has a result to write
- mem1_wb_reg  in  5  memory1 destination
- mem1_wb_data  in  XLEN  memory1 result
- mem1_wb_ready  out  1  memory1 write accepted this cycle; memory1 holds when low
- md_issue_valid  in  1  decode issues a mul/div op this cycle
- md_issue_reg  in  5  its destination
- md_wb_valid  in  1  mul/div result available
- md_wb_reg  in  5  mul/div destination
- md_wb_data  in  XLEN  mul/div result
- md_wb_ready  out  1  result captured into holding buffer
- de_rs1, de_rs2, de_rd  in  5 each  decode operands/destination
- de_uses_rs1, de_uses_rs2, de_writes_rd  in  1 each  qualifiers
- sb_stall  out  1  decode must hold
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data

## Operation
- Holding buffer: one entry (hb_valid, hb_reg, hb_data).
  - md_wb_ready = !hb_valid.
  - A handshake (md_wb_valid & md_wb_ready) loads the buffer at the next edge.
- Two-state FSM:
  - NORMAL: mem1 has priority. Grant to mem1 when mem1_wb_valid; otherwise grant to the buffer when hb_valid.
  - FORCE: grant to the buffer unconditionally; mem1_wb_ready = 0.
- Transitions:
  - NORMAL->FORCE when starve_cnt == STARVE_LIMIT-1 and the buffer is denied this cycle.
  - FORCE->NORMAL always after one cycle, since the buffer drains.
- starve_cnt (4 bits):
  - Increments each cycle hb_valid is set and the buffer is not granted.
  - Clears on buffer grant or when hb_valid = 0.
  - Saturates at STARVE_LIMIT.
- mem1_wb_ready = 1 in NORMAL, including when mem1_wb_valid = 0.
- Register-file outputs:
  - rf_we = granted source valid and destination nonzero. A write to x0 is still a grant (it consumes the slot, clears the buffer and the scoreboard) but rf_we = 0.
  - rf_waddr and rf_wdata come from the granted source and are 0 when there is no grant.
- Scoreboard (32 bits, bit 0 hardwired 0):
  - Set on md_issue_valid for md_issue_reg.
  - Cleared when the buffer is granted for hb_reg.
  - Simultaneous set and clear of the same bit: set wins.
- sb_stall = (de_uses_rs1 & sb[de_rs1]) | (de_uses_rs2 & sb[de_rs2]) | (de_writes_rd & sb[de_rd]).
  - The rd term guarantees no two pending writes to one register, and no mem1 write to a pending register.

## Timing
- Reset values: hb_valid = 0, FSM = NORMAL, starve_cnt = 0, scoreboard = 0.
  - Hence md_wb_ready = 1, mem1_wb_ready = 1, sb_stall = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0.
- Reset asserted mid-operation discards the buffer and the scoreboard immediately (asynchronous).
- rf_* are combinational from the granted source. The register file writes at the same edge.
- mem1 latency: 0 cycles.
- mul/div result path:
  - Minimum 1 cycle from md handshake to rf_we (buffer granted the next cycle).
  - Maximum STARVE_LIMIT+1 cycles.
- Scoreboard bit:
  - Visible to sb_stall the cycle after issue.
  - Clear is visible the cycle after the buffer write. The register file already holds the value at that edge, so no bypass is needed.
- md_wb_ready is low for at least one cycle after each capture; back-to-back results need 2 cycles each.
- In FORCE, mem1 holds its inputs stable; they are accepted the following cycle.

## Structure
- In the shared defines header: wb_arb_state_t (NORMAL, FORCE) and the wb_hold_t struct {valid, reg, data}.
- The scoreboard is a natural sub-module, md_scoreboard: set/clear ports and three lookup ports. It is reusable for a future FPU.
- Everything else is flat.

## Test plan
- Reset: hold rst_n = 0 with random inputs.
  - Required: all outputs at reset values.
  - Release; mem1 writes reg 5 = 0x1234 → rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234 the same cycle.
- Idle port: md result reg 7 = 0xAA with mem1 idle.
  - Required: md_wb_ready = 0 the next cycle; rf write 7 = 0xAA that cycle; ready = 1 after.
- Starvation: mem1 valid every cycle, md result buffered, STARVE_LIMIT = 4.
  - Required: 4 denied cycles, then FORCE with mem1_wb_ready = 0 and buffer written; mem1 resumes the next cycle.
- Scoreboard: issue md to reg 10; decode presents rs1 = 10, then rd = 10, then rs2 = 10.
  - Required: sb_stall = 1 each cycle until the buffer writes reg 10; 0 the cycle after.
- Simultaneous set/clear: issue md to reg 3 in the same cycle a buffered result for reg 3 is written.
  - Required: sb[3] remains 1.
- Destination x0: issue md to x0 → sb_stall never set.
  - Buffered result for reg 0 → granted, rf_we = 0, buffer cleared.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter and its mul/div scoreboard.
package wb_port_arbiter_pkg;

    localparam int unsigned WB_XLEN  = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } wb_arb_state_t;

    // Holding-buffer width follows WB_XLEN; widen it together with the top-level XLEN.
    typedef struct packed {
        logic               valid;
        logic [4:0]         dst;
        logic [WB_XLEN-1:0] data;
    } wb_hold_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input logic [4:0] idx);
        logic [NUM_REGS-1:0] mask;
        mask = {NUM_REGS{1'b0}};
        if (en) begin
            mask[idx] = 1'b1;
        end else begin
            mask = {NUM_REGS{1'b0}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register, x0 never pending.
module md_scoreboard
    import wb_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_valid_i,
    input  logic [4:0] set_idx_i,
    input  logic       clr_valid_i,
    input  logic [4:0] clr_idx_i,
    input  logic [4:0] rs1_idx_i,
    input  logic [4:0] rs2_idx_i,
    input  logic [4:0] rd_idx_i,
    output logic       rs1_hit_o,
    output logic       rs2_hit_o,
    output logic       rd_hit_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Next pending set: clear first, then set, so a same-cycle re-issue keeps the bit.
    always_comb begin
        pending_d    = (pending_q & ~reg_onehot(clr_valid_i, clr_idx_i))
                     | reg_onehot(set_valid_i, set_idx_i);
        pending_d[0] = 1'b0;
    end

    // Pending bit storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= {NUM_REGS{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rs1_hit_o = pending_q[rs1_idx_i];
    assign rs2_hit_o = pending_q[rs2_idx_i];
    assign rd_hit_o  = pending_q[rd_idx_i];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between memory1 writeback and a buffered mul/div
// result, with a starvation escape and a decode stall for pending mul/div destinations.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN         = WB_XLEN,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem1_wb_valid,
    input  logic [4:0]      mem1_wb_reg,
    input  logic [XLEN-1:0] mem1_wb_data,
    output logic            mem1_wb_ready,
    input  logic            md_issue_valid,
    input  logic [4:0]      md_issue_reg,
    input  logic            md_wb_valid,
    input  logic [4:0]      md_wb_reg,
    input  logic [XLEN-1:0] md_wb_data,
    output logic            md_wb_ready,
    input  logic [4:0]      de_rs1,
    input  logic [4:0]      de_rs2,
    input  logic [4:0]      de_rd,
    input  logic            de_uses_rs1,
    input  logic            de_uses_rs2,
    input  logic            de_writes_rd,
    output logic            sb_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam logic [3:0] LIMIT_C    = 4'(STARVE_LIMIT);
    localparam logic [3:0] LIMIT_M1_C = 4'(STARVE_LIMIT - 1);

    wb_arb_state_t state_q, state_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    wb_hold_t      hb_q, hb_d;

    logic grant_mem1_s;
    logic grant_hb_s;
    logic md_hs_s;
    logic rs1_hit_s, rs2_hit_s, rd_hit_s;

    assign md_wb_ready   = ~hb_q.valid;
    assign mem1_wb_ready = (state_q == ST_NORMAL);
    assign md_hs_s       = md_wb_valid & ~hb_q.valid;

    // Grant selection; mem1 is masked during reset so the port stays quiet.
    always_comb begin
        grant_mem1_s = 1'b0;
        grant_hb_s   = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                grant_mem1_s = rst_n & mem1_wb_valid;
                grant_hb_s   = hb_q.valid & ~mem1_wb_valid;
            end
            ST_FORCE: begin
                grant_mem1_s = 1'b0;
                grant_hb_s   = hb_q.valid;
            end
            default: begin
                grant_mem1_s = 1'b0;
                grant_hb_s   = 1'b0;
            end
        endcase
    end

    // Register-file write mux from the granted source; x0 consumes the slot without a write.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = {XLEN{1'b0}};
        if (grant_mem1_s) begin
            rf_we    = (mem1_wb_reg != 5'd0);
            rf_waddr = mem1_wb_reg;
            rf_wdata = mem1_wb_data;
        end else if (grant_hb_s) begin
            rf_we    = (hb_q.dst != 5'd0);
            rf_waddr = hb_q.dst;
            rf_wdata = XLEN'(hb_q.data);
        end else begin
            rf_we    = 1'b0;
        end
    end

    // Next-state for arbitration FSM, starvation counter and holding buffer.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        hb_d         = hb_q;

        case (state_q)
            ST_NORMAL: begin
                if (hb_q.valid && !grant_hb_s && starve_cnt_q == LIMIT_M1_C) begin
                    state_d = ST_FORCE;
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            ST_FORCE: state_d = ST_NORMAL;
            default:  state_d = ST_NORMAL;
        endcase

        if (!hb_q.valid || grant_hb_s) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        // Load and drain are exclusive: capture needs an empty buffer, drain a full one.
        if (md_hs_s) begin
            hb_d.valid = 1'b1;
            hb_d.dst   = md_wb_reg;
            hb_d.data  = WB_XLEN'(md_wb_data);
        end else if (grant_hb_s) begin
            hb_d.valid = 1'b0;
        end else begin
            hb_d = hb_q;
        end
    end

    // State, counter and buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= 4'd0;
            hb_q         <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            hb_q         <= hb_d;
        end
    end

    md_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid_i (md_issue_valid),
        .set_idx_i   (md_issue_reg),
        .clr_valid_i (grant_hb_s),
        .clr_idx_i   (hb_q.dst),
        .rs1_idx_i   (de_rs1),
        .rs2_idx_i   (de_rs2),
        .rd_idx_i    (de_rd),
        .rs1_hit_o   (rs1_hit_s),
        .rs2_hit_o   (rs2_hit_s),
        .rd_hit_o    (rd_hit_s)
    );

    assign sb_stall = (de_uses_rs1 & rs1_hit_s) | (de_uses_rs2 & rs2_hit_s) | (de_writes_rd & rd_hit_s);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, idle-port drain, starvation, scoreboard, x0.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mem1_wb_valid;
    logic [4:0]  mem1_wb_reg;
    logic [31:0] mem1_wb_data;
    logic        mem1_wb_ready;
    logic        md_issue_valid;
    logic [4:0]  md_issue_reg;
    logic        md_wb_valid;
    logic [4:0]  md_wb_reg;
    logic [31:0] md_wb_data;
    logic        md_wb_ready;
    logic [4:0]  de_rs1, de_rs2, de_rd;
    logic        de_uses_rs1, de_uses_rs2, de_writes_rd;
    logic        sb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks;
    int errors;

    wb_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem1_wb_valid  (mem1_wb_valid),
        .mem1_wb_reg    (mem1_wb_reg),
        .mem1_wb_data   (mem1_wb_data),
        .mem1_wb_ready  (mem1_wb_ready),
        .md_issue_valid (md_issue_valid),
        .md_issue_reg   (md_issue_reg),
        .md_wb_valid    (md_wb_valid),
        .md_wb_reg      (md_wb_reg),
        .md_wb_data     (md_wb_data),
        .md_wb_ready    (md_wb_ready),
        .de_rs1         (de_rs1),
        .de_rs2         (de_rs2),
        .de_rd          (de_rd),
        .de_uses_rs1    (de_uses_rs1),
        .de_uses_rs2    (de_uses_rs2),
        .de_writes_rd   (de_writes_rd),
        .sb_stall       (sb_stall),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        mem1_wb_valid = 1'b0; mem1_wb_reg = 5'd0; mem1_wb_data = 32'd0;
        md_issue_valid = 1'b0; md_issue_reg = 5'd0;
        md_wb_valid = 1'b0; md_wb_reg = 5'd0; md_wb_data = 32'd0;
        de_rs1 = 5'd0; de_rs2 = 5'd0; de_rd = 5'd0;
        de_uses_rs1 = 1'b0; de_uses_rs2 = 1'b0; de_writes_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem1_wb_valid = 1'($urandom); mem1_wb_reg = 5'($urandom); mem1_wb_data = $urandom;
            md_issue_valid = 1'($urandom); md_issue_reg = 5'($urandom);
            md_wb_valid = 1'($urandom); md_wb_reg = 5'($urandom); md_wb_data = $urandom;
            de_rs1 = 5'($urandom); de_rs2 = 5'($urandom); de_rd = 5'($urandom);
            de_uses_rs1 = 1'b1; de_uses_rs2 = 1'b1; de_writes_rd = 1'b1;
            settle();
            checks++;
            if ({md_wb_ready, mem1_wb_ready, sb_stall, rf_we, rf_waddr, rf_wdata} !==
                {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
                errors++;
                $display("FAIL reset_outputs got md_rdy=%0b m1_rdy=%0b stall=%0b we=%0b addr=%0d data=%h want 1 1 0 0 0 0",
                         md_wb_ready, mem1_wb_ready, sb_stall, rf_we, rf_waddr, rf_wdata);
            end
            step();
        end
        clear_inputs();
        rst_n = 1'b1;
        mem1_wb_valid = 1'b1; mem1_wb_reg = 5'd5; mem1_wb_data = 32'h1234;
        settle();
        checks++;
        if ({mem1_wb_ready, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin
            errors++;
            $display("FAIL reset_first_mem1 got rdy=%0b we=%0b addr=%0d data=%h want 1 1 5 00001234",
                     mem1_wb_ready, rf_we, rf_waddr, rf_wdata);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_idle_port();
        md_wb_valid = 1'b1; md_wb_reg = 5'd7; md_wb_data = 32'hAA;
        settle();
        checks++;
        if ({md_wb_ready, rf_we} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL idle_capture got rdy=%0b we=%0b want 1 0", md_wb_ready, rf_we);
        end
        step();
        md_wb_valid = 1'b0;
        settle();
        checks++;
        if ({md_wb_ready, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd7, 32'hAA}) begin
            errors++;
            $display("FAIL idle_drain got rdy=%0b we=%0b addr=%0d data=%h want 0 1 7 000000aa",
                     md_wb_ready, rf_we, rf_waddr, rf_wdata);
        end
        step();
        settle();
        checks++;
        if ({md_wb_ready, rf_we, rf_waddr} !== {1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL idle_after got rdy=%0b we=%0b addr=%0d want 1 0 0", md_wb_ready, rf_we, rf_waddr);
        end
        step();
    endtask

    task automatic test_back_to_back();
        md_wb_valid = 1'b1; md_wb_reg = 5'd11; md_wb_data = 32'h1111;
        settle();
        checks++;
        if (md_wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ready got %0b want 1", md_wb_ready);
        end
        step();
        md_wb_reg = 5'd12; md_wb_data = 32'h2222;
        settle();
        checks++;
        if ({md_wb_ready, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd11, 32'h1111}) begin
            errors++;
            $display("FAIL b2b_first_write got rdy=%0b we=%0b addr=%0d data=%h want 0 1 11 00001111",
                     md_wb_ready, rf_we, rf_waddr, rf_wdata);
        end
        step();
        settle();
        checks++;
        if ({md_wb_ready, rf_we} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second_capture got rdy=%0b we=%0b want 1 0", md_wb_ready, rf_we);
        end
        step();
        md_wb_valid = 1'b0;
        settle();
        checks++;
        if ({md_wb_ready, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd12, 32'h2222}) begin
            errors++;
            $display("FAIL b2b_second_write got rdy=%0b we=%0b addr=%0d data=%h want 0 1 12 00002222",
                     md_wb_ready, rf_we, rf_waddr, rf_wdata);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_starvation();
        mem1_wb_valid = 1'b1; mem1_wb_reg = 5'd1; mem1_wb_data = 32'h100;
        md_wb_valid = 1'b1; md_wb_reg = 5'd9; md_wb_data = 32'hBEEF;
        settle();
        checks++;
        if ({md_wb_ready, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h100}) begin
            errors++;
            $display("FAIL starve_capture got rdy=%0b addr=%0d data=%h want 1 1 00000100", md_wb_ready, rf_waddr, rf_wdata);
        end
        step();
        md_wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem1_wb_reg = 5'(2 + i); mem1_wb_data = 32'h200 + 32'(i);
            settle();
            checks++;
            if ({mem1_wb_ready, md_wb_ready, rf_we, rf_waddr, rf_wdata} !==
                {1'b1, 1'b0, 1'b1, 5'(2 + i), 32'h200 + 32'(i)}) begin
                errors++;
                $display("FAIL starve_denied_%0d got m1_rdy=%0b md_rdy=%0b we=%0b addr=%0d data=%h want 1 0 1 %0d %h",
                         i, mem1_wb_ready, md_wb_ready, rf_we, rf_waddr, rf_wdata, 2 + i, 32'h200 + 32'(i));
            end
            step();
        end
        mem1_wb_reg = 5'd6; mem1_wb_data = 32'h600;
        settle();
        checks++;
        if ({mem1_wb_ready, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd9, 32'hBEEF}) begin
            errors++;
            $display("FAIL starve_force got m1_rdy=%0b we=%0b addr=%0d data=%h want 0 1 9 0000beef",
                     mem1_wb_ready, rf_we, rf_waddr, rf_wdata);
        end
        step();
        settle();
        checks++;
        if ({mem1_wb_ready, md_wb_ready, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 1'b1, 5'd6, 32'h600}) begin
            errors++;
            $display("FAIL starve_resume got m1_rdy=%0b md_rdy=%0b we=%0b addr=%0d data=%h want 1 1 1 6 00000600",
                     mem1_wb_ready, md_wb_ready, rf_we, rf_waddr, rf_wdata);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        md_issue_valid = 1'b1; md_issue_reg = 5'd10;
        de_rs1 = 5'd10; de_uses_rs1 = 1'b1;
        settle();
        checks++;
        if (sb_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_issue_cycle got stall=%0b want 0", sb_stall);
        end
        step();
        md_issue_valid = 1'b0;
        settle();
        checks++;
        if (sb_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_rs1_hit got stall=%0b want 1", sb_stall);
        end
        step();
        de_uses_rs1 = 1'b0; de_rd = 5'd10; de_writes_rd = 1'b1;
        settle();
        checks++;
        if (sb_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_rd_hit got stall=%0b want 1", sb_stall);
        end
        step();
        de_writes_rd = 1'b0; de_rs2 = 5'd10; de_uses_rs2 = 1'b1;
        md_wb_valid = 1'b1; md_wb_reg = 5'd10; md_wb_data = 32'h55;
        settle();
        checks++;
        if (sb_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_rs2_hit got stall=%0b want 1", sb_stall);
        end
        step();
        md_wb_valid = 1'b0;
        settle();
        checks++;
        if ({sb_stall, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd10, 32'h55}) begin
            errors++;
            $display("FAIL sb_write_cycle got stall=%0b we=%0b addr=%0d data=%h want 1 1 10 00000055",
                     sb_stall, rf_we, rf_waddr, rf_wdata);
        end
        step();
        settle();
        checks++;
        if (sb_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared got stall=%0b want 0", sb_stall);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_set_clear();
        md_issue_valid = 1'b1; md_issue_reg = 5'd3;
        md_wb_valid = 1'b1; md_wb_reg = 5'd3; md_wb_data = 32'h33;
        step();
        md_wb_valid = 1'b0;
        settle();
        checks++;
        if ({rf_we, rf_waddr} !== {1'b1, 5'd3}) begin
            errors++;
            $display("FAIL setclr_write got we=%0b addr=%0d want 1 3", rf_we, rf_waddr);
        end
        step();
        md_issue_valid = 1'b0;
        de_rs1 = 5'd3; de_uses_rs1 = 1'b1;
        settle();
        checks++;
        if (sb_stall !== 1'b1) begin
            errors++;
            $display("FAIL setclr_set_wins got stall=%0b want 1", sb_stall);
        end
        md_wb_valid = 1'b1; md_wb_reg = 5'd3; md_wb_data = 32'h34;
        step();
        md_wb_valid = 1'b0;
        step();
        settle();
        checks++;
        if (sb_stall !== 1'b0) begin
            errors++;
            $display("FAIL setclr_final_clear got stall=%0b want 0", sb_stall);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_x0();
        md_issue_valid = 1'b1; md_issue_reg = 5'd0;
        step();
        md_issue_valid = 1'b0;
        de_rs1 = 5'd0; de_uses_rs1 = 1'b1; de_rd = 5'd0; de_writes_rd = 1'b1;
        settle();
        checks++;
        if (sb_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_no_stall got stall=%0b want 0", sb_stall);
        end
        md_wb_valid = 1'b1; md_wb_reg = 5'd0; md_wb_data = 32'hFF;
        step();
        md_wb_valid = 1'b0;
        settle();
        checks++;
        if ({md_wb_ready, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b0, 5'd0, 32'hFF}) begin
            errors++;
            $display("FAIL x0_grant got rdy=%0b we=%0b addr=%0d data=%h want 0 0 0 000000ff",
                     md_wb_ready, rf_we, rf_waddr, rf_wdata);
        end
        step();
        settle();
        checks++;
        if ({md_wb_ready, sb_stall, rf_wdata} !== {1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL x0_buffer_cleared got rdy=%0b stall=%0b data=%h want 1 0 0", md_wb_ready, sb_stall, rf_wdata);
        end
        step();
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_idle_port();
        test_back_to_back();
        test_starvation();
        test_scoreboard();
        test_set_clear();
        test_x0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
